// File: rtl/rvx_i2c_target_responder_pkg.sv
// Shared FSM encodings and bus constants for the I2C target responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rvx_i2c_target_responder_pkg;

    // 4-bit state encodings for the responder FSM
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_PTR       = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8,
        ST_WAIT_STOP = 4'd9
    } state_t;

    // SDA levels of the ninth (acknowledge) bit
    localparam logic ACK_LVL  = 1'b0;
    localparam logic NACK_LVL = 1'b1;

    // Reserved general-call address
    localparam logic [6:0] GENERAL_CALL_ADDR = 7'h00;

    // Register pointer advance, wrapping 8'hFF -> 8'h00
    function automatic logic [7:0] ptr_next(input logic [7:0] ptr);
        return ptr + 8'd1;
    endfunction

endpackage

// File: rtl/rvx_i2c_target_responder_if.sv
// Local register-file access bus driven by the I2C target responder.
// Latency: strobes are single cycle; reg_rdata is expected the cycle after reg_rd_en.
// Backpressure: none; the register file must accept every strobe.
// Ports: reg_wr_en/reg_rd_en strobes, reg_addr pointer, reg_wdata write data, reg_rdata read data.
interface rvx_i2c_target_responder_if;
    import rvx_i2c_target_responder_pkg::*;

    logic       reg_wr_en;
    logic       reg_rd_en;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;

    // master: the responder; slave: the local register file
    modport master (output reg_wr_en, reg_rd_en, reg_addr, reg_wdata, input reg_rdata);
    modport slave  (input reg_wr_en, reg_rd_en, reg_addr, reg_wdata, output reg_rdata);

endinterface

// File: rtl/rvx_i2c_line_filter.sv
// Synchronises one asynchronous I2C pad, filters glitches and flags level edges.
// Latency: 2 sync cycles + FILTER_LEN cycles from pad change to filtered level/edge flag.
// Backpressure: none (free-running sampler).
// Ports: clk, rstnn, pad_in (async) -> lvl (filtered), rise/fall (one-cycle flags with lvl change).
module rvx_i2c_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rstnn,
    input  logic pad_in,
    output logic lvl,
    output logic rise,
    output logic fall
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // Sync chain and level preset to 1: an idle bus is pulled high.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            sync <= 2'b11;
            lvl  <= 1'b1;
            cnt  <= '0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[0], pad_in};
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync[1] == lvl) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                // FILTER_LEN consecutive differing samples: accept new level
                lvl  <= sync[1];
                cnt  <= '0;
                rise <= sync[1];
                fall <= ~sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rvx_i2c_target_responder.sv
// I2C target: decodes START/STOP, matches DEVICE_ADDR, maps pointer reads/writes onto reg_bus.
// Latency: line filter (2+FILTER_LEN cycles) then 1 cycle to strobes; read data reaches SDA 2 cycles after reg_rd_en.
// Backpressure: none; no clock stretching, register file must respond on time.
// Ports: clk, rstnn, i2c_scl_in/i2c_sda_in pads, i2c_sda_oe (1 = pull low), busy, irq_wr_done, reg_bus (master).
// Option: RVX_I2C_TARGET_GENERAL_CALL_EN also ACKs address 7'h00+W and writes data from pointer 8'h00.
module rvx_i2c_target_responder
    import rvx_i2c_target_responder_pkg::*;
#(
    parameter logic [6:0] DEVICE_ADDR = 7'h50,
    parameter int         FILTER_LEN  = 3
) (
    input  logic                               clk,
    input  logic                               rstnn,
    input  logic                               i2c_scl_in,
    input  logic                               i2c_sda_in,
    output logic                               i2c_sda_oe,
    output logic                               busy,
    output logic                               irq_wr_done,
    rvx_i2c_target_responder_if.master         reg_bus
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    rvx_i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk    (clk),
        .rstnn  (rstnn),
        .pad_in (i2c_scl_in),
        .lvl    (scl_lvl),
        .rise   (scl_rise),
        .fall   (scl_fall)
    );

    rvx_i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk    (clk),
        .rstnn  (rstnn),
        .pad_in (i2c_sda_in),
        .lvl    (sda_lvl),
        .rise   (sda_rise),
        .fall   (sda_fall)
    );

    logic start_det, stop_det;
    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;

    state_t     state, ack_next;
    logic [3:0] bit_cnt;
    logic [7:0] shift;
    logic [7:0] ptr;
    logic       sda_oe;
    logic       wr_en, rd_en, rd_latch;
    logic [7:0] addr, wdata;
    logic       wr_flag;

    // Byte as it will stand once the SDA level sampled on this SCL rise is shifted in
    logic [7:0] byte_in;
    assign byte_in = {shift[6:0], sda_lvl};

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state       <= ST_IDLE;
            ack_next    <= ST_IDLE;
            bit_cnt     <= 4'd0;
            shift       <= 8'h00;
            ptr         <= 8'h00;
            sda_oe      <= 1'b0;
            wr_en       <= 1'b0;
            rd_en       <= 1'b0;
            rd_latch    <= 1'b0;
            addr        <= 8'h00;
            wdata       <= 8'h00;
            wr_flag     <= 1'b0;
            busy        <= 1'b0;
            irq_wr_done <= 1'b0;
        end else begin
            wr_en       <= 1'b0;
            rd_en       <= 1'b0;
            irq_wr_done <= 1'b0;
            rd_latch    <= rd_en;

            if (start_det) begin
                state    <= ST_ADDR;
                bit_cnt  <= 4'd0;
                sda_oe   <= 1'b0;
                wr_flag  <= 1'b0;
                rd_latch <= 1'b0;
            end else if (stop_det) begin
                state       <= ST_IDLE;
                bit_cnt     <= 4'd0;
                sda_oe      <= 1'b0;
                busy        <= 1'b0;
                irq_wr_done <= wr_flag;
                wr_flag     <= 1'b0;
                rd_latch    <= 1'b0;
            end else begin
                // Register file answered the read strobe: load byte and present its MSB
                if (rd_latch) begin
                    shift  <= reg_bus.reg_rdata;
                    sda_oe <= ~reg_bus.reg_rdata[7];
                    ptr    <= ptr_next(ptr);
                end

                unique case (state)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift   <= byte_in;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                if (byte_in[7:1] == DEVICE_ADDR) begin
                                    state    <= ST_ADDR_ACK;
                                    busy     <= 1'b1;
                                    ack_next <= byte_in[0] ? ST_RDATA : ST_PTR;
                                end
`ifdef RVX_I2C_TARGET_GENERAL_CALL_EN
                                else if (byte_in[7:1] == GENERAL_CALL_ADDR && !byte_in[0]) begin
                                    // General call skips the pointer phase
                                    state    <= ST_ADDR_ACK;
                                    busy     <= 1'b1;
                                    ack_next <= ST_WDATA;
                                    ptr      <= 8'h00;
                                end
`endif
                                else begin
                                    state <= ST_WAIT_STOP;
                                    busy  <= 1'b0;
                                end
                            end
                        end
                    end

                    ST_PTR: begin
                        if (scl_rise) begin
                            shift   <= byte_in;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                ptr      <= byte_in;
                                state    <= ST_PTR_ACK;
                                ack_next <= ST_WDATA;
                            end
                        end
                    end

                    ST_WDATA: begin
                        if (scl_rise) begin
                            shift   <= byte_in;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                wr_en    <= 1'b1;
                                addr     <= ptr;
                                wdata    <= byte_in;
                                ptr      <= ptr_next(ptr);
                                wr_flag  <= 1'b1;
                                state    <= ST_WDATA_ACK;
                                ack_next <= ST_WDATA;
                            end
                        end
                    end

                    // bit_cnt==8 marks the SCL fall ending bit 8 (start driving the ACK);
                    // the following fall ends the ACK clock.
                    ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe  <= 1'b1;
                                bit_cnt <= 4'd0;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= ack_next;
                                if (ack_next == ST_RDATA) begin
                                    rd_en <= 1'b1;
                                    addr  <= ptr;
                                end
                            end
                        end
                    end

                    ST_RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= 4'd0;
                                state   <= ST_RDATA_ACK;
                            end else if (bit_cnt != 4'd0) begin
                                shift  <= {shift[6:0], 1'b0};
                                sda_oe <= ~shift[6];
                            end
                        end
                    end

                    // bit_cnt==1 records a controller ACK until the ACK clock falls
                    ST_RDATA_ACK: begin
                        if (scl_rise) begin
                            if (sda_lvl == NACK_LVL) begin
                                state <= ST_WAIT_STOP;
                                busy  <= 1'b0;
                            end else begin
                                bit_cnt <= 4'd1;
                            end
                        end else if (scl_fall && bit_cnt == 4'd1) begin
                            rd_en   <= 1'b1;
                            addr    <= ptr;
                            bit_cnt <= 4'd0;
                            state   <= ST_RDATA;
                        end
                    end

                    default: begin
                        // IDLE and WAIT_STOP ignore bit traffic until START/STOP
                    end
                endcase
            end
        end
    end

    assign i2c_sda_oe        = sda_oe;
    assign reg_bus.reg_wr_en = wr_en;
    assign reg_bus.reg_rd_en = rd_en;
    assign reg_bus.reg_addr  = addr;
    assign reg_bus.reg_wdata = wdata;

endmodule

// File: tb/tb_rvx_i2c_target_responder.sv
// Directed bench: bit-banged I2C controller on a wired-AND bus plus a register-file model.
// Latency: n/a.
// Backpressure: n/a.
module tb_rvx_i2c_target_responder;

    localparam int QP = 8;   // clock cycles per quarter SCL period

    logic clk   = 1'b0;
    logic rstnn = 1'b0;
    logic scl_drv = 1'b1;
    logic sda_drv = 1'b1;
    logic sda_line;
    logic sda_oe, busy, irq_wr_done;

    int checks = 0;
    int errors = 0;

    rvx_i2c_target_responder_if rbus ();

    assign sda_line = sda_drv & ~sda_oe;

    rvx_i2c_target_responder #(
        .DEVICE_ADDR (7'h50),
        .FILTER_LEN  (3)
    ) dut (
        .clk         (clk),
        .rstnn       (rstnn),
        .i2c_scl_in  (scl_drv),
        .i2c_sda_in  (sda_line),
        .i2c_sda_oe  (sda_oe),
        .busy        (busy),
        .irq_wr_done (irq_wr_done),
        .reg_bus     (rbus.master)
    );

    always #5 clk = ~clk;

    // Register file model: read data registered one cycle after the strobe
    function automatic logic [7:0] rom(input logic [7:0] a);
        if (a == 8'h20) return 8'h81;
        if (a == 8'h21) return 8'h7E;
        return a ^ 8'h5A;
    endfunction

    int         wr_cnt  = 0;
    int         rd_cnt  = 0;
    int         irq_cnt = 0;
    logic [7:0] wr_addr_log [64];
    logic [7:0] wr_data_log [64];
    logic [7:0] rd_addr_log [64];

    always @(posedge clk) begin
        if (rbus.reg_wr_en) begin
            wr_addr_log[wr_cnt % 64] <= rbus.reg_addr;
            wr_data_log[wr_cnt % 64] <= rbus.reg_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        if (rbus.reg_rd_en) begin
            rd_addr_log[rd_cnt % 64] <= rbus.reg_addr;
            rd_cnt <= rd_cnt + 1;
            rbus.reg_rdata <= rom(rbus.reg_addr);
        end
        if (irq_wr_done) irq_cnt <= irq_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic qwait();
        repeat (QP) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1; qwait();
        scl_drv = 1'b1; qwait();
        sda_drv = 1'b0; qwait();
        scl_drv = 1'b0; qwait();
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; qwait();
        scl_drv = 1'b1; qwait();
        sda_drv = 1'b1; qwait();
        qwait();
    endtask

    task automatic clk_bit(input logic b, output logic s);
        sda_drv = b;    qwait();
        scl_drv = 1'b1; qwait();
        s = sda_line;   qwait();
        scl_drv = 1'b0; qwait();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
        clk_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            d[i] = s;
        end
        clk_bit(nack, s);
    endtask

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] d;
        int         wb, rb, ib;

        // ---------------- reset state ----------------
        repeat (5) @(negedge clk);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_irq", irq_wr_done, 0);
        check("rst_wr_en", rbus.reg_wr_en, 0);
        check("rst_rd_en", rbus.reg_rd_en, 0);
        check("rst_addr", rbus.reg_addr, 0);
        rstnn = 1'b1;
        repeat (10) @(negedge clk);

        // ---------------- write 0x10 <- A5, 3C ----------------
        wb = wr_cnt; ib = irq_cnt;
        i2c_start();
        write_byte(8'hA0, ack); check("t1_addr_ack", ack, 0);
        check("t1_busy", busy, 1);
        write_byte(8'h10, ack); check("t1_ptr_ack", ack, 0);
        write_byte(8'hA5, ack); check("t1_d0_ack", ack, 0);
        write_byte(8'h3C, ack); check("t1_d1_ack", ack, 0);
        check("t1_irq_before_stop", irq_cnt - ib, 0);
        i2c_stop();
        check("t1_wr_cnt", wr_cnt - wb, 2);
        check("t1_w0_addr", wr_addr_log[wb], 8'h10);
        check("t1_w0_data", wr_data_log[wb], 8'hA5);
        check("t1_w1_addr", wr_addr_log[wb + 1], 8'h11);
        check("t1_w1_data", wr_data_log[wb + 1], 8'h3C);
        check("t1_irq", irq_cnt - ib, 1);
        check("t1_busy_after", busy, 0);

        // ---------------- ptr 0x20, rSTART, read 2 bytes ----------------
        wb = wr_cnt; rb = rd_cnt; ib = irq_cnt;
        i2c_start();
        write_byte(8'hA0, ack); check("t2_addr_ack", ack, 0);
        write_byte(8'h20, ack); check("t2_ptr_ack", ack, 0);
        i2c_start();
        write_byte(8'hA1, ack); check("t2_raddr_ack", ack, 0);
        read_byte(1'b0, d);     check("t2_byte0", d, 8'h81);
        read_byte(1'b1, d);     check("t2_byte1", d, 8'h7E);
        check("t2_sda_released", sda_oe, 0);
        check("t2_busy_nack", busy, 0);
        i2c_stop();
        check("t2_rd_cnt", rd_cnt - rb, 2);
        check("t2_r0_addr", rd_addr_log[rb], 8'h20);
        check("t2_r1_addr", rd_addr_log[rb + 1], 8'h21);
        check("t2_wr_cnt", wr_cnt - wb, 0);
        check("t2_irq", irq_cnt - ib, 0);

        // ---------------- address mismatch, then normal write ----------------
        wb = wr_cnt; rb = rd_cnt; ib = irq_cnt;
        i2c_start();
        write_byte(8'hA2, ack); check("t3_nack", ack, 1);
        check("t3_busy", busy, 0);
        write_byte(8'h33, ack); check("t3_ignored_ack", ack, 1);
        i2c_stop();
        check("t3_no_wr", wr_cnt - wb, 0);
        check("t3_no_rd", rd_cnt - rb, 0);
        check("t3_no_irq", irq_cnt - ib, 0);
        i2c_start();
        write_byte(8'hA0, ack); check("t3_addr_ack", ack, 0);
        write_byte(8'h30, ack); check("t3_ptr_ack", ack, 0);
        write_byte(8'h44, ack); check("t3_d_ack", ack, 0);
        i2c_stop();
        check("t3_wr_cnt", wr_cnt - wb, 1);
        check("t3_w_addr", wr_addr_log[wb], 8'h30);
        check("t3_w_data", wr_data_log[wb], 8'h44);
        check("t3_irq", irq_cnt - ib, 1);

        // ---------------- pointer wrap 0xFF -> 0x00 ----------------
        wb = wr_cnt;
        i2c_start();
        write_byte(8'hA0, ack); check("t4_addr_ack", ack, 0);
        write_byte(8'hFF, ack); check("t4_ptr_ack", ack, 0);
        write_byte(8'h11, ack); check("t4_d0_ack", ack, 0);
        write_byte(8'h22, ack); check("t4_d1_ack", ack, 0);
        i2c_stop();
        check("t4_wr_cnt", wr_cnt - wb, 2);
        check("t4_w0_addr", wr_addr_log[wb], 8'hFF);
        check("t4_w0_data", wr_data_log[wb], 8'h11);
        check("t4_w1_addr", wr_addr_log[wb + 1], 8'h00);
        check("t4_w1_data", wr_data_log[wb + 1], 8'h22);

        // ---------------- reset during a read ----------------
        rb = rd_cnt;
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h20, ack);
        i2c_start();
        write_byte(8'hA1, ack); check("t5_raddr_ack", ack, 0);
        // first three bits of 0x81 are 1,0,0; the fourth (0) is now driven low
        clk_bit(1'b1, s); check("t5_bit7", s, 1);
        clk_bit(1'b1, s); check("t5_bit6", s, 0);
        clk_bit(1'b1, s); check("t5_bit5", s, 0);
        check("t5_driving", sda_oe, 1);
        scl_drv = 1'b1;
        @(posedge clk);
        #2 rstnn = 1'b0;
        #1 check("t5_async_release", sda_oe, 0);
        check("t5_busy_rst", busy, 0);
        sda_drv = 1'b1;
        repeat (10) @(negedge clk);
        rstnn = 1'b1;
        repeat (10) @(negedge clk);
        check("t5_sda_after", sda_oe, 0);
        // Pointer back at 0x00: a bare read returns rom(0x00)
        rb = rd_cnt;
        i2c_start();
        write_byte(8'hA1, ack); check("t5_idle_addr_ack", ack, 0);
        read_byte(1'b1, d);     check("t5_ptr0_data", d, 8'h5A);
        i2c_stop();
        check("t5_rd_cnt", rd_cnt - rb, 1);
        check("t5_r_addr", rd_addr_log[rb], 8'h00);

        // ---------------- general call ----------------
        wb = wr_cnt;
        i2c_start();
        write_byte(8'h00, ack);
`ifdef RVX_I2C_TARGET_GENERAL_CALL_EN
        check("t6_gc_ack", ack, 0);
        write_byte(8'h06, ack); check("t6_gc_data_ack", ack, 0);
        i2c_stop();
        check("t6_gc_wr_cnt", wr_cnt - wb, 1);
        check("t6_gc_addr", wr_addr_log[wb], 8'h00);
        check("t6_gc_data", wr_data_log[wb], 8'h06);
`else
        check("t6_gc_nack", ack, 1);
        write_byte(8'h06, ack); check("t6_gc_data_nack", ack, 1);
        i2c_stop();
        check("t6_gc_no_wr", wr_cnt - wb, 0);
`endif
        check("t6_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
